// File: rtl/wave_loader.sv
// Wavetable loader: decodes a SysEx-style half-wave frame, verifies its checksum and
// commits the 64 samples into the sample RAM at {program, index}.
module wave_loader #(
    parameter logic [7:0] MFR_ID = 8'h7D,
    parameter int         NSAMP  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [12:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);
    localparam logic [5:0] LAST_IDX = 6'(NSAMP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MFR, S_PROG, S_DHI, S_DLO, S_CKS, S_EOX, S_COMMIT
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] prog_q;
    logic [6:0] cks_q;
    logic [5:0] idx_q;
    logic [3:0] hi_q;
    logic [7:0] sample_buf [NSAMP];
    logic       done_q, error_q;
    logic       err;

    logic accept, is_rt, is_f0, is_data, is_nib;
    assign accept  = rx_valid && rx_ready;
    assign is_rt   = rx_data >= 8'hF8;
    assign is_f0   = rx_data == 8'hF0;
    assign is_data = !rx_data[7];
    assign is_nib  = rx_data[7:4] == 4'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        err     = 1'b0;
        unique case (state_q)
            S_IDLE:   if (accept && is_f0) state_d = S_MFR;
            S_COMMIT: if (idx_q == LAST_IDX) state_d = S_IDLE;
            default: begin
                // Realtime bytes pass through every receive state untouched.
                if (accept && !is_rt) begin
                    if (is_f0) begin
                        state_d = S_MFR;
                    end else begin
                        unique case (state_q)
                            S_MFR:  state_d = (rx_data == MFR_ID) ? S_PROG : S_IDLE;
                            S_PROG: if (is_data) state_d = S_DHI; else err = 1'b1;
                            S_DHI:  if (is_nib) state_d = S_DLO; else err = 1'b1;
                            S_DLO:  if (is_nib) state_d = (idx_q == LAST_IDX) ? S_CKS : S_DHI;
                                    else err = 1'b1;
                            S_CKS:  if (rx_data == {1'b0, cks_q}) state_d = S_EOX; else err = 1'b1;
                            S_EOX:  if (rx_data == 8'hF7) state_d = S_COMMIT; else err = 1'b1;
                            default: state_d = S_IDLE;
                        endcase
                        if (err) state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_q  <= '0;
            cks_q   <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= (state_q == S_COMMIT) && (idx_q == LAST_IDX);
            error_q <= err;
            if (accept && state_q == S_PROG && is_data) begin
                prog_q <= rx_data[6:0];
                cks_q  <= rx_data[6:0];
                idx_q  <= '0;
            end
            if (accept && state_q == S_DHI && is_nib) begin
                hi_q  <= rx_data[3:0];
                cks_q <= cks_q ^ rx_data[6:0];
            end
            // The index wraps from 63 to 0, so the commit pass starts at sample 0.
            if (accept && state_q == S_DLO && is_nib) begin
                cks_q <= cks_q ^ rx_data[6:0];
                idx_q <= idx_q + 6'd1;
            end
            if (state_q == S_COMMIT) idx_q <= idx_q + 6'd1;
        end
    end

    // NOTE: the sample buffer has no reset; its contents are only read after a full frame fills it.
    always_ff @(posedge clk) begin
        if (accept && state_q == S_DLO && is_nib) sample_buf[idx_q] <= {hi_q, rx_data[3:0]};
    end

    always_comb begin
        rx_ready   = state_q != S_COMMIT;
        busy       = state_q != S_IDLE;
        wr_en      = state_q == S_COMMIT;
        wr_addr    = wr_en ? {prog_q, idx_q} : 13'd0;
        wr_data    = wr_en ? sample_buf[idx_q] : 8'd0;
        load_done  = done_q;
        load_error = error_q;
    end
endmodule

// File: doc/wave_loader.md
Name: wave_loader

Overview:
- Writer side of the wavetable sample store.
- Accepts a SysEx-style byte stream and decodes one 64-sample, 8-bit half-wave for a chosen program.
- Verifies a checksum, then commits the 64 samples into the sample RAM at address {program, index}.
- This is the same layout the NCO sample path reads from.

Parameters:
- MFR_ID, 8'h7D, manufacturer byte required after 0xF0.
- NSAMP, 64, samples per wave; fixed, index width 6.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  incoming stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- wr_en  out  1  sample RAM write strobe
- wr_addr  out  13  {program[6:0], index[5:0]}
- wr_data  out  8  sample value
- busy  out  1  high from accepted 0xF0 until commit or abort ends
- load_done  out  1  one-cycle pulse, wave committed
- load_error  out  1  one-cycle pulse, frame aborted

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0 except rx_ready=1.
  - Buffer contents don't care; program/checksum/index registers 0.
- Frame format: F0, MFR_ID, prog (0x00-0x7F), 128 nibble bytes, cks, F7.
  - Nibble bytes come in pairs, high nibble then low nibble, for samples 0..63.
  - Each nibble byte is 0x00-0x0F.
  - cks = 7-bit XOR of prog and all 128 nibble bytes.
- A byte is consumed only on the handshake. rx_ready=1 in every state except COMMIT.
- Realtime bytes 0xF8-0xFF are accepted and ignored in every receive state, with no state change.
- States and transitions:
  - IDLE: F0 -> MFR. Any other byte is dropped, no error.
  - MFR: MFR_ID -> PROG. Any other byte other than F0 -> IDLE silently (foreign SysEx).
  - PROG: 0x00-0x7F -> store prog, cks<=prog, idx<=0 -> DHI.
  - DHI: 0x00-0x0F -> hold hi nibble, cks^=byte -> DLO.
  - DLO: 0x00-0x0F -> buf[idx]<={hi,lo}, cks^=byte. If idx==63 -> CKS, else idx++ -> DHI.
  - CKS: byte==cks -> EOX. Mismatch (0x00-0x7F) -> error.
  - EOX: F7 -> COMMIT. Anything else (0x00-0xF7) -> error.
  - COMMIT: 64 consecutive cycles, rx_ready=0.
    - Cycle k: wr_en=1, wr_addr={prog,k}, wr_data=buf[k].
    - After k=63: load_done=1 for one cycle, busy=0, -> IDLE.
    - No other write ever occurs.
- Error (data byte 0x10-0x7F in DHI/DLO, bad cks, non-F7 in EOX, status byte 0x80-0xF7 other than F0 in PROG..EOX):
  - load_error pulse next cycle, -> IDLE.
  - No RAM writes; RAM keeps the previous wave.
- F0 received in any state PROG..EOX: restart the frame -> MFR, no error pulse, busy stays 1.
- Latency: last accepted F7 -> first wr_en on next cycle. load_done 64 cycles after the first write, in the cycle after the last write.
- Asynchronous reset mid-commit: writes stop immediately. Samples already written remain; this is accepted behaviour. No done/error pulse.
- wr_addr/wr_data are 0 whenever wr_en=0.
- load_done and load_error are never high together.

Test Plan:
- Frame prog=0x05, samples k -> 4*k (8-bit wrap), correct cks, F7 -> 64 writes addr 0x0140..0x017F, data 0x00,0x04,..,0xFC; load_done one cycle after addr 0x017F; rx_ready low exactly 64 cycles.
- Same frame with cks XOR 0x01 -> load_error pulse, zero wr_en; a following valid frame for prog 0x05 commits normally.
- Nibble byte 0x1A at sample 10 hi -> load_error, IDLE; subsequent bytes ignored until the next F0.
- Insert F8 and FE between every data byte of a valid prog=0x7F frame -> identical writes at 0x1FC0..0x1FFF, load_done.
- F0 7D 03 plus 20 nibble bytes, then F0 7D 03 plus a full valid frame -> no load_error; a single commit with the second frame's data.
- Assert rst_n low at commit write k=30 -> wr_en drops in the same cycle, outputs 0, rx_ready=1, busy=0; no done/error pulse after release.
